regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//   Shares the register file's single write port (we3/a3/wd3) between NUM_REQ writeback sources (ALU, load unit, CSR/misc).
//   Round-robin arbitration over valid/ready requests; the granted request is registered onto the write port.
//   Sits between the writeback stage sources and register_file; also reports contention statistics.
// PARAMETERS
//   NUM_REQ  3   number of write requesters (2..8)
//   AW       5   register address width (drives a3)
//   DW       32  write data width (drives wd3)
//   CNT_W    16  width of the contention counter
// PORTS
//   clk          in   1            system clock, rising edge
//   rst          in   1            asynchronous reset, active-high
//   req_valid    in   NUM_REQ      requester i has a write pending
//   req_addr     in   NUM_REQ*AW   dest register of requester i (slice [i*AW +: AW])
//   req_data     in   NUM_REQ*DW   write data of requester i (slice [i*DW +: DW])
//   req_ready    out  NUM_REQ      one-hot grant; transfer when valid&ready
//   we3          out  1            to register_file write enable (registered)
//   a3           out  AW           to register_file write address (registered)
//   wd3          out  DW           to register_file write data (registered)
//   grant_id     out  3            index of last granted requester (registered)
//   contend_cnt  out  CNT_W        saturating count of cycles with >1 valid request
// BEHAVIOUR
//   - Reset (async, rst=1): rr_ptr=0, we3=0, a3=0, wd3=0, grant_id=0, contend_cnt=0; req_ready all 0 while rst=1.
//   - req_ready is combinational: scan from rr_ptr upward (mod NUM_REQ), first i with req_valid[i]=1 gets ready[i]=1; at most one bit set; no valid -> all 0.
//   - Requesters hold valid/addr/data stable until ready; ready never depends on req_addr/req_data.
//   - Grant in cycle t -> at posedge end of t: we3<=1 (0 if addr==0), a3<=addr, wd3<=data, grant_id<=i, rr_ptr<=(i+1) mod NUM_REQ.
//   - No grant in cycle t -> we3<=0 next cycle; a3/wd3/grant_id/rr_ptr hold.
//   - Latency: grant to we3 high = 1 cycle; register file updated at the following edge (2 edges after grant).
//   - Writes to register 0: granted and consume a slot (pointer advances) but we3 stays 0.
//   - Same-address requests in one cycle: served in round-robin order on successive cycles; the later write wins.
//   - Fairness: a continuously valid requester is granted within NUM_REQ cycles.
//   - contend_cnt: +1 on each cycle with popcount(req_valid)>=2; saturates at all-ones, no wrap.
//   - rst asserted mid-transfer: pending output write is dropped (we3 forced 0 immediately); requesters re-present after reset.
//   - rr_ptr wrap: after granting NUM_REQ-1, pointer returns to 0.
// STRUCTURE
//   - regfile_pkg: REG_AW=5, REG_DW=32, REG_ZERO=5'd0, NUM_WB_SRC=3.
//   - Sub-module rr_arbiter #(N): req in, one-hot grant out, internal rotating pointer with update enable; reusable for read-port sharing.
//   - Top: rr_arbiter + grant-select mux for addr/data + output register + contention counter.
// TESTING
//   1. Reset: rst=1 with random inputs -> we3=0, a3=0, wd3=0, contend_cnt=0, req_ready=0; release -> rr_ptr=0.
//   2. Single source: req_valid=001, addr=5, data=0xDEADBEEF -> ready=001 same cycle; next cycle we3=1,a3=5,wd3=0xDEADBEEF; register 5 reads 0xDEADBEEF after next edge.
//   3. All three valid 4 cycles -> grants 0,1,2,0; grant_id follows 0,1,2,0; contend_cnt=4 (valid kept high).
//   4. x0 write: req_valid=010, addr=0, data=0x1234 -> ready=010, we3 stays 0, rr_ptr advances to 2.
//   5. Same addr: req0 addr=7 data=0xA, req1 addr=7 data=0xB, ptr=0 -> we3 writes 0xA then 0xB; reg7 ends 0xB.
//   6. Saturation/reset: CNT_W=4, 20 contended cycles -> contend_cnt=15; rst pulse mid-grant -> we3=0 same cycle, counter 0.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter slice.
//   REG_AW / REG_DW : register file address / data widths
//   REG_ZERO        : hard-wired zero register (writes are dropped)
//   NUM_WB_SRC      : writeback sources sharing the port (ALU, load, CSR/misc)
//   idx_w()         : width of a binary index into n requesters
package regfile_wr_arbiter_pkg;

  localparam int REG_AW     = 5;
  localparam int REG_DW     = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  localparam int NUM_WB_SRC = 3;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request bundle: NUM_REQ valid/ready requesters, each carrying a
// destination register and write data.
//   req_valid : requester i has a write pending
//   req_addr  : dest register of requester i, slice [i*AW +: AW]
//   req_data  : write data of requester i, slice [i*DW +: DW]
//   req_ready : one-hot grant back to the requesters
// master = the writeback sources, slave = the arbiter.
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_SRC,
  parameter int AW      = REG_AW,
  parameter int DW      = REG_DW
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);

endinterface

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Generic round-robin arbiter with a rotating priority pointer.
//   clk, rst : clock, asynchronous active-high reset (pointer -> 0)
//   req      : request vector
//   update   : when high and a request is granted, the pointer moves to
//              the slot just after the winner
//   gnt      : one-hot grant (combinational)
//   gnt_idx  : binary index of the granted slot (0 when nothing granted)
// Reusable for read-port sharing as well as write-port sharing.
module rr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int  N  = 3,
  localparam int PW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          update,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] ptr;
  logic          found;

  // Scan offsets 0..N-1 from the pointer; the first valid slot wins.
  // The inner loop compares against every slot so that all indices stay
  // constant after unrolling.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (((int'(ptr) + k) % N) == i)) begin
          found   = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = PW'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (update && found) begin
      ptr <= (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port between NUM_REQ writeback
// sources using round-robin arbitration, and counts contention cycles.
//   clk, rst    : clock, asynchronous active-high reset
//   req         : request bundle (slave side); req_ready is the one-hot grant
//   we3/a3/wd3  : registered write port toward register_file
//   grant_id    : index of the last granted requester (registered)
//   contend_cnt : saturating count of cycles with two or more valid requests
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int  NUM_REQ = NUM_WB_SRC,
  parameter int  AW      = REG_AW,
  parameter int  DW      = REG_DW,
  parameter int  CNT_W   = 16,
  localparam int PW      = idx_w(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  regfile_wr_arbiter_if.slave req,
  output logic                we3,
  output logic [AW-1:0]       a3,
  output logic [DW-1:0]       wd3,
  output logic [2:0]          grant_id,
  output logic [CNT_W-1:0]    contend_cnt
);

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic               accept;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic multi_valid(input logic [NUM_REQ-1:0] v);
    return $countones(v) >= 2;
  endfunction

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req.req_valid),
    .update  (accept),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept        = |gnt;
  assign req.req_ready = rst ? '0 : gnt;

  // One-hot grant selects the winning requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr = req.req_addr[k*AW +: AW];
        sel_data = req.req_data[k*DW +: DW];
      end
    end
  end

  // ---- grant -> write-port register stage ----
  // A grant to x0 still consumes the slot but never raises the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3      <= 1'b0;
      a3       <= '0;
      wd3      <= '0;
      grant_id <= '0;
    end else if (accept) begin
      we3      <= (sel_addr != AW'(REG_ZERO));
      a3       <= sel_addr;
      wd3      <= sel_data;
      grant_id <= 3'(gnt_idx);
    end else begin
      we3      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contend_cnt <= '0;
    end else if (multi_valid(req.req_valid)) begin
      contend_cnt <= sat_inc(contend_cnt);
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized valid/ready traffic, scored against a behavioural model of the
// arbitration rules and a shadow register file.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    valid = '0;
  logic [N*AW-1:0] addr  = '0;
  logic [N*DW-1:0] data  = '0;

  regfile_wr_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus_a ();
  regfile_wr_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus_b ();

  assign bus_a.req_valid = valid;
  assign bus_a.req_addr  = addr;
  assign bus_a.req_data  = data;
  assign bus_b.req_valid = valid;
  assign bus_b.req_addr  = addr;
  assign bus_b.req_data  = data;

  logic          we3_a, we3_b;
  logic [AW-1:0] a3_a, a3_b;
  logic [DW-1:0] wd3_a, wd3_b;
  logic [2:0]    gid_a, gid_b;
  logic [15:0]   cnt_a;
  logic [3:0]    cnt_b;

  regfile_wr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .req(bus_a.slave), .we3(we3_a), .a3(a3_a),
    .wd3(wd3_a), .grant_id(gid_a), .contend_cnt(cnt_a)
  );

  regfile_wr_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req(bus_b.slave), .we3(we3_b), .a3(a3_b),
    .wd3(wd3_b), .grant_id(gid_b), .contend_cnt(cnt_b)
  );

  // Reference model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_a;
  logic [31:0] m_wd;
  int          m_gid;
  int          m_cnt16, m_cnt4;
  int          last_g;
  logic [31:0] rf_exp [32];
  logic [31:0] rf_act [32];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(addr >> (i*AW));
  endfunction

  function automatic logic [DW-1:0] data_of(input int i);
    return DW'(data >> (i*DW));
  endfunction

  // First requester at or after the pointer (mod N) holding valid; -1 if none.
  function automatic int model_grant();
    int vm = int'(valid);
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (((vm >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [N-1:0]    bm;
    logic [N*AW-1:0] am, av;
    logic [N*DW-1:0] dm, dv;
    bm = N'(1) << i;
    am = '0; am[AW-1:0] = {AW{1'b1}};
    av = '0; av[AW-1:0] = a;
    dm = '0; dm[DW-1:0] = {DW{1'b1}};
    dv = '0; dv[DW-1:0] = d;
    valid = v ? (valid | bm) : (valid & ~bm);
    addr  = (addr & ~(am << (i*AW))) | (av << (i*AW));
    data  = (data & ~(dm << (i*DW))) | (dv << (i*DW));
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_we3"},  64'(we3_a), 64'(m_we));
    chk({tag, "_a3"},   64'(a3_a),  64'(m_a));
    chk({tag, "_wd3"},  64'(wd3_a), 64'(m_wd));
    chk({tag, "_gid"},  64'(gid_a), 64'(m_gid));
    chk({tag, "_cnt"},  64'(cnt_a), 64'(m_cnt16));
    chk({tag, "_cnt4"}, 64'(cnt_b), 64'(m_cnt4));
    chk({tag, "_we3b"}, 64'(we3_b), 64'(m_we));
  endtask

  // One clock cycle with the currently driven requests.
  task automatic step(input string tag);
    int          g;
    logic        pw, aw;
    logic [4:0]  pa, aa;
    logic [31:0] pd, ad;
    #1;
    g = model_grant();
    chk({tag, "_rdy"},  64'(bus_a.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    chk({tag, "_rdyb"}, 64'(bus_b.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    pw = m_we;  pa = m_a;  pd = m_wd;
    aw = we3_a; aa = a3_a; ad = wd3_a;
    @(posedge clk);
    if (aw === 1'b1) rf_act[aa] = ad;
    if (pw) rf_exp[pa] = pd;
    if ($countones(valid) >= 2) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (g >= 0) begin
      m_we  = (addr_of(g) != 0);
      m_a   = addr_of(g);
      m_wd  = data_of(g);
      m_gid = g;
      m_ptr = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    last_g = g;
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse with random request inputs present.
  task automatic do_reset();
    rst   = 1'b1;
    valid = N'($urandom);
    addr  = (N*AW)'($urandom);
    data  = {$urandom, $urandom, $urandom};
    m_ptr = 0; m_we = 1'b0; m_a = '0; m_wd = '0; m_gid = 0;
    m_cnt16 = 0; m_cnt4 = 0;
    #1;
    check_outputs("rst");
    chk("rst_rdy",  64'(bus_a.req_ready), 64'd0);
    chk("rst_rdyb", 64'(bus_b.req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    chk("rst_hold_rdy", 64'(bus_a.req_ready), 64'd0);
    rst   = 1'b0;
    valid = '0;
  endtask

  int exp_gid [4] = '{0, 1, 2, 0};

  initial begin
    for (int r = 0; r < 32; r++) begin
      rf_exp[r] = '0;
      rf_act[r] = '0;
    end
    last_g = -1;
    #2;

    // Reset
    do_reset();

    // Single source write to x5
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    step("t2a");
    chk("t2_we3", 64'(we3_a), 64'd1);
    chk("t2_a3",  64'(a3_a),  64'd5);
    chk("t2_wd3", 64'(wd3_a), 64'hDEADBEEF);
    valid = '0;
    step("t2b");
    chk("t2_rf5", 64'(rf_act[5]), 64'hDEADBEEF);

    // All three valid for four cycles from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 10), 32'h100 + 32'(i));
    for (int c = 0; c < 4; c++) begin
      step("t3");
      chk("t3_gid_seq", 64'(gid_a), 64'(exp_gid[c]));
    end
    chk("t3_cnt", 64'(cnt_a), 64'd4);
    valid = '0;

    // x0 write from requester 1: granted, pointer advances, no write enable
    set_req(1, 1'b1, 5'd0, 32'h1234);
    step("t4a");
    chk("t4_we3", 64'(we3_a), 64'd0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 20), 32'h200 + 32'(i));
    step("t4b");
    chk("t4_ptr2", 64'(gid_a), 64'd2);
    valid = '0;
    step("t4c");

    // Same destination from two requesters: later grant wins
    do_reset();
    set_req(0, 1'b1, 5'd7, 32'hA);
    set_req(1, 1'b1, 5'd7, 32'hB);
    step("t5a");
    chk("t5_wd3_first", 64'(wd3_a), 64'hA);
    set_req(0, 1'b0, 5'd7, 32'hA);
    step("t5b");
    chk("t5_wd3_second", 64'(wd3_a), 64'hB);
    valid = '0;
    step("t5c");
    step("t5d");
    chk("t5_rf7", 64'(rf_act[7]), 64'hB);

    // Counter saturation on the narrow instance, then reset mid-transfer
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    for (int c = 0; c < 20; c++) step("t6");
    chk("t6_sat", 64'(cnt_b), 64'd15);
    chk("t6_we_pending", 64'(we3_a), 64'd1);
    do_reset();

    // Randomized traffic: requesters hold until granted
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (((int'(valid) >> i) & 1) == 0 && $urandom_range(0, 2) == 0)
          set_req(i, 1'b1, 5'($urandom_range(0, 7)), $urandom);
      end
      step("rnd");
      if (last_g >= 0) set_req(last_g, 1'b0, addr_of(last_g), data_of(last_g));
      if ($urandom_range(0, 96) == 0) do_reset();
    end
    valid = '0;
    step("drain_a");
    step("drain_b");
    for (int r = 0; r < 32; r++) chk("rf_final", 64'(rf_act[r]), 64'(rf_exp[r]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
